// File: rtl/ai_pkg.sv
// Shared state encoding and default tuning values for the autopilot.
package ai_pkg;

    localparam int PLAYER_X_DEF      = 6;
    localparam int JUMP_WIN_DEF      = 30;
    localparam int DUCK_WIN_DEF      = 40;
    localparam int JUMP_HOLD_DEF     = 20;
    localparam int RESTART_DELAY_DEF = 60;

    typedef enum logic [2:0] {
        WATCH,
        JUMP,
        DUCK,
        CRASHED,
        RESTART
    } ai_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ai_threat_detect.sv
// Per-lane obstacle window compare, OR-reduced into ground and air threats.
module ai_threat_detect
    import ai_pkg::*;
#(
    parameter int NUM_OBS  = 2,
    parameter int POS_W    = 10,
    parameter int PLAYER_X = PLAYER_X_DEF,
    parameter int JUMP_WIN = JUMP_WIN_DEF,
    parameter int DUCK_WIN = DUCK_WIN_DEF
) (
    input  logic [NUM_OBS*POS_W-1:0] obs_pos,
    input  logic [NUM_OBS-1:0]       obs_air,
    output logic                     ground_threat,
    output logic                     air_threat
);

    localparam logic [POS_W-1:0] PLAYER_POS = POS_W'(PLAYER_X);
    localparam logic [POS_W-1:0] JUMP_POS   = POS_W'(JUMP_WIN);
    localparam logic [POS_W-1:0] DUCK_POS   = POS_W'(DUCK_WIN);

    logic [NUM_OBS-1:0] ground_hit;
    logic [NUM_OBS-1:0] air_hit;

    // Window is exclusive at the player and inclusive at the trigger point.
    generate
        for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_lane
            logic [POS_W-1:0] lane_pos;
            logic             in_front;
            assign lane_pos       = obs_pos[gi*POS_W +: POS_W];
            assign in_front       = (lane_pos > PLAYER_POS);
            assign ground_hit[gi] = !obs_air[gi] && in_front && (lane_pos <= JUMP_POS);
            assign air_hit[gi]    =  obs_air[gi] && in_front && (lane_pos <= DUCK_POS);
        end
    endgenerate

    assign ground_threat = |ground_hit;
    assign air_threat    = |air_hit;

endmodule

// File: rtl/ai_autopilot.sv
// Autopilot FSM: jumps ground obstacles, ducks air obstacles, auto-restarts after a crash.
module ai_autopilot
    import ai_pkg::*;
#(
    parameter int NUM_OBS       = 2,
    parameter int POS_W         = 10,
    parameter int PLAYER_X      = PLAYER_X_DEF,
    parameter int JUMP_WIN      = JUMP_WIN_DEF,
    parameter int DUCK_WIN      = DUCK_WIN_DEF,
    parameter int JUMP_HOLD     = JUMP_HOLD_DEF,
    parameter int RESTART_DELAY = RESTART_DELAY_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_OBS*POS_W-1:0] obs_pos,
    input  logic [NUM_OBS-1:0]       obs_air,
    input  logic                     crash,
    output logic                     button_up,
    output logic                     button_down,
    output logic                     crash_out,
    output logic [7:0]               crash_count
);

    localparam int CNT_MAX = max_int(JUMP_HOLD, RESTART_DELAY);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Loads are one short because the terminal cycle is the one spent at zero.
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(JUMP_HOLD - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(RESTART_DELAY - 1);

    ai_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             button_up_reg, button_down_reg, crash_out_reg;
    logic [7:0]       crash_count_reg;
    logic             crash_event;

    logic ground_threat, air_threat;
    logic ground_act, air_act;

    ai_threat_detect #(
        .NUM_OBS  (NUM_OBS),
        .POS_W    (POS_W),
        .PLAYER_X (PLAYER_X),
        .JUMP_WIN (JUMP_WIN),
        .DUCK_WIN (DUCK_WIN)
    ) u_threat (
        .obs_pos       (obs_pos),
        .obs_air       (obs_air),
        .ground_threat (ground_threat),
        .air_threat    (air_threat)
    );

    assign ground_act = enable && ground_threat;
    assign air_act    = enable && air_threat;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        crash_event = 1'b0;
        case (state_reg)
            WATCH: begin
                if (crash) begin
                    state_next  = CRASHED;
                    cnt_next    = DELAY_LOAD;
                    crash_event = 1'b1;
                end else if (ground_act) begin
                    state_next = JUMP;
                    cnt_next   = HOLD_LOAD;
                end else if (air_act) begin
                    state_next = DUCK;
                end
            end
            JUMP: begin
                if (crash) begin
                    state_next  = CRASHED;
                    cnt_next    = DELAY_LOAD;
                    crash_event = 1'b1;
                end else if (!enable || cnt_reg == '0) begin
                    state_next = WATCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DUCK: begin
                if (crash) begin
                    state_next  = CRASHED;
                    cnt_next    = DELAY_LOAD;
                    crash_event = 1'b1;
                end else if (!enable) begin
                    state_next = WATCH;
                end else if (ground_act) begin
                    state_next = JUMP;
                    cnt_next   = HOLD_LOAD;
                end else if (!air_act) begin
                    state_next = WATCH;
                end
            end
            CRASHED: begin
                // Disabled cycles freeze the delay, pushing the restart out.
                if (enable) begin
                    if (cnt_reg == '0) begin
                        state_next = RESTART;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end
            RESTART: begin
                state_next = WATCH;
                cnt_next   = '0;
            end
            default: begin
                state_next = WATCH;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change one edge after the cause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= WATCH;
            cnt_reg         <= '0;
            button_up_reg   <= 1'b0;
            button_down_reg <= 1'b0;
            crash_out_reg   <= 1'b0;
            crash_count_reg <= 8'd0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            button_up_reg   <= (state_next == JUMP) || (state_next == RESTART);
            button_down_reg <= (state_next == DUCK);
            crash_out_reg   <= (state_next == CRASHED);
            if (crash_event && crash_count_reg != 8'hFF) begin
                crash_count_reg <= crash_count_reg + 8'd1;
            end
        end
    end

    assign button_up   = button_up_reg;
    assign button_down = button_down_reg;
    assign crash_out   = crash_out_reg;
    assign crash_count = crash_count_reg;

endmodule

// File: tb/tb_ai_autopilot.sv
// Directed bench for ai_autopilot with hand-computed expectations.
module tb_ai_autopilot;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [19:0] obs_pos;
    logic [1:0]  obs_air;
    logic        crash;
    logic        button_up;
    logic        button_down;
    logic        crash_out;
    logic [7:0]  crash_count;

    int checks   = 0;
    int failures = 0;
    int seen_up;

    localparam logic [9:0] FAR = 10'd500;

    always #5 clk = ~clk;

    ai_autopilot dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .obs_pos     (obs_pos),
        .obs_air     (obs_air),
        .crash       (crash),
        .button_up   (button_up),
        .button_down (button_down),
        .crash_out   (crash_out),
        .crash_count (crash_count)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_obs(input logic [9:0] p0, input logic a0,
                           input logic [9:0] p1, input logic a1);
        obs_pos = {p1, p0};
        obs_air = {a1, a0};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        crash  = 1'b0;
        set_obs(FAR, 1'b0, FAR, 1'b0);
        tick(2);
        chk("reset_up", 32'(button_up), 32'd0);
        chk("reset_down", 32'(button_down), 32'd0);
        chk("reset_crash_out", 32'(crash_out), 32'd0);
        chk("reset_count", 32'(crash_count), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("idle_up", 32'(button_up), 32'd0);

        // Ground obstacle one past the window and at the player: no press.
        set_obs(10'd31, 1'b0, FAR, 1'b0);
        tick(2);
        chk("ground31_up", 32'(button_up), 32'd0);
        set_obs(10'd6, 1'b0, FAR, 1'b0);
        tick(2);
        chk("ground6_up", 32'(button_up), 32'd0);

        // Ground at 30, held throughout: exactly 20 cycles of button_up.
        set_obs(10'd30, 1'b0, FAR, 1'b0);
        tick(1);
        chk("jump_first", 32'(button_up), 32'd1);
        tick(19);
        chk("jump_20th", 32'(button_up), 32'd1);
        set_obs(FAR, 1'b0, FAR, 1'b0);
        tick(1);
        chk("jump_end", 32'(button_up), 32'd0);
        tick(1);

        // Air obstacles: 41 and 6 do not trigger.
        set_obs(FAR, 1'b0, 10'd41, 1'b1);
        tick(2);
        chk("air41_down", 32'(button_down), 32'd0);
        set_obs(FAR, 1'b0, 10'd6, 1'b1);
        tick(2);
        chk("air6_down", 32'(button_down), 32'd0);

        // Air at lane1 pos 40 for 5 cycles.
        set_obs(FAR, 1'b0, 10'd40, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk($sformatf("duck_c%0d", i), 32'(button_down), 32'd1);
        end
        set_obs(FAR, 1'b0, FAR, 1'b0);
        tick(1);
        chk("duck_release", 32'(button_down), 32'd0);

        // Air threat then ground at 25: duck to jump on one edge.
        set_obs(FAR, 1'b0, 10'd35, 1'b1);
        tick(1);
        chk("duck2_down", 32'(button_down), 32'd1);
        set_obs(10'd25, 1'b0, 10'd35, 1'b1);
        tick(1);
        chk("swap_down", 32'(button_down), 32'd0);
        chk("swap_up", 32'(button_up), 32'd1);
        set_obs(FAR, 1'b0, FAR, 1'b0);
        tick(19);
        chk("swap_hold", 32'(button_up), 32'd1);
        tick(1);
        chk("swap_end", 32'(button_up), 32'd0);

        // enable=0 aborts a jump and holds WATCH despite a threat.
        set_obs(10'd30, 1'b0, FAR, 1'b0);
        tick(1);
        chk("en_jump", 32'(button_up), 32'd1);
        enable = 1'b0;
        tick(1);
        chk("en_abort", 32'(button_up), 32'd0);
        tick(2);
        chk("en_hold", 32'(button_up), 32'd0);
        set_obs(FAR, 1'b0, FAR, 1'b0);
        enable = 1'b1;
        tick(1);

        // Crash, a second crash during CRASHED, restart after 60 cycles.
        crash = 1'b1;
        tick(1);
        crash = 1'b0;
        chk("crash_out", 32'(crash_out), 32'd1);
        chk("crash_cnt1", 32'(crash_count), 32'd1);
        tick(10);
        crash = 1'b1;
        tick(1);
        crash = 1'b0;
        tick(48);
        chk("crash_60_out", 32'(crash_out), 32'd1);
        chk("crash_60_up", 32'(button_up), 32'd0);
        chk("crash_ignored", 32'(crash_count), 32'd1);
        tick(1);
        chk("restart_up", 32'(button_up), 32'd1);
        chk("restart_out", 32'(crash_out), 32'd0);
        tick(1);
        chk("restart_done", 32'(button_up), 32'd0);

        // Freeze CRASHED delay for 5 disabled cycles: restart 5 cycles late.
        crash = 1'b1;
        tick(1);
        crash = 1'b0;
        chk("frz_cnt2", 32'(crash_count), 32'd2);
        tick(9);
        enable = 1'b0;
        tick(5);
        chk("frz_out", 32'(crash_out), 32'd1);
        enable = 1'b1;
        tick(45);
        chk("frz_nominal", 32'(button_up), 32'd0);
        tick(5);
        chk("frz_late_out", 32'(crash_out), 32'd1);
        tick(1);
        chk("frz_restart", 32'(button_up), 32'd1);
        tick(1);

        // Reset mid-CRASHED: no restart press afterwards.
        crash = 1'b1;
        tick(1);
        crash = 1'b0;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        chk("rstc_out", 32'(crash_out), 32'd0);
        chk("rstc_cnt", 32'(crash_count), 32'd0);
        rst_n = 1'b1;
        seen_up = 0;
        for (int i = 0; i < 70; i++) begin
            tick(1);
            if (button_up) seen_up++;
        end
        chk("rstc_no_restart", 32'(seen_up), 32'd0);

        // Reset mid-JUMP aborts the press.
        set_obs(10'd30, 1'b0, FAR, 1'b0);
        tick(2);
        set_obs(FAR, 1'b0, FAR, 1'b0);
        rst_n = 1'b0;
        tick(1);
        chk("rstj_up", 32'(button_up), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("rstj_after", 32'(button_up), 32'd0);

        // Crash detection still counts with enable=0.
        enable = 1'b0;
        crash  = 1'b1;
        tick(1);
        crash  = 1'b0;
        enable = 1'b1;
        chk("dis_crash_cnt", 32'(crash_count), 32'd1);
        chk("dis_crash_out", 32'(crash_out), 32'd1);
        tick(61);

        // 255 more crashes: count saturates at 255.
        for (int i = 0; i < 255; i++) begin
            crash = 1'b1;
            tick(1);
            crash = 1'b0;
            tick(61);
        end
        chk("sat_count", 32'(crash_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
